// File: rtl/intr_arbiter.sv
// intr_arbiter: PDP-11 style BR-level interrupt arbiter.
// Collects level-sensitive device requests, picks the eligible device with the
// highest BR level (lowest index on ties), presents a single request and vector
// to the CPU, and returns a one-cycle one-hot acknowledge to the granted device.
// Optional build macro INTR_PREEMPT_EN: when defined, a strictly higher-level
// eligible request abandons a pending grant so the arbiter can re-arbitrate.
module intr_arbiter #(
  parameter int NDEV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NDEV-1:0]     dev_irq,
  input  logic [8*NDEV-1:0]   dev_vector,
  input  logic [3*NDEV-1:0]   dev_level,
  input  logic [2:0]          cpu_ipl,
  input  logic                cpu_int_ack,
  output logic                interrupt,
  output logic [7:0]          vector,
  output logic [2:0]          int_level,
  output logic [NDEV-1:0]     dev_ack
);

  localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACKED   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   win_q, win_d;
  logic [7:0]        vec_q, vec_d;
  logic [2:0]        lvl_q, lvl_d;

  logic              any_eligible;
  logic [IDXW-1:0]   best_idx;
  logic [2:0]        best_level;
  logic [7:0]        best_vector;
  logic              win_irq;

  // Find the eligible device with the highest level; strict compare keeps the lowest index on ties
  always_comb begin
    any_eligible = 1'b0;
    best_idx     = '0;
    best_level   = 3'd0;
    best_vector  = 8'd0;
    for (int i = 0; i < NDEV; i++) begin
      if (dev_irq[i] && (dev_level[3*i +: 3] > cpu_ipl)) begin
        if (!any_eligible || (dev_level[3*i +: 3] > best_level)) begin
          any_eligible = 1'b1;
          best_idx     = IDXW'(i);
          best_level   = dev_level[3*i +: 3];
          best_vector  = {dev_vector[8*i+2 +: 6], 2'b00};
        end
      end
    end
  end

  // Request line of the currently latched winner, used to detect withdrawal
  always_comb begin
    win_irq = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      if (win_q == IDXW'(i)) win_irq = dev_irq[i];
    end
  end

  // Next-state and latch-update logic; vector and level only change when a new grant is taken
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          state_d = PENDING;
          win_d   = best_idx;
          vec_d   = best_vector;
          lvl_d   = best_level;
        end
      end
      PENDING: begin
        if (cpu_int_ack) begin
          state_d = ACKED;
        end else if (!win_irq || (cpu_ipl >= lvl_q)) begin
          state_d = IDLE;
`ifdef INTR_PREEMPT_EN
        end else if (any_eligible && (best_level > lvl_q)) begin
          state_d = IDLE;
`endif
        end
      end
      ACKED: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-grant registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      vec_q   <= 8'd0;
      lvl_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      vec_q   <= vec_d;
      lvl_q   <= lvl_d;
    end
  end

  // One-hot acknowledge to the granted device, only during the ACKED cycle
  always_comb begin
    dev_ack = '0;
    if (state_q == ACKED) begin
      for (int i = 0; i < NDEV; i++) begin
        if (win_q == IDXW'(i)) dev_ack[i] = 1'b1;
      end
    end
  end

  assign interrupt = (state_q == PENDING);
  assign vector    = vec_q;
  assign int_level = lvl_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter: directed self-checking bench for intr_arbiter (NDEV=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_intr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  dev_irq;
  logic [31:0] dev_vector;
  logic [11:0] dev_level;
  logic [2:0]  cpu_ipl;
  logic        cpu_int_ack;
  logic        interrupt;
  logic [7:0]  vector;
  logic [2:0]  int_level;
  logic [3:0]  dev_ack;

  int checks;
  int failures;

  intr_arbiter #(.NDEV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .dev_irq     (dev_irq),
    .dev_vector  (dev_vector),
    .dev_level   (dev_level),
    .cpu_ipl     (cpu_ipl),
    .cpu_int_ack (cpu_int_ack),
    .interrupt   (interrupt),
    .vector      (vector),
    .int_level   (int_level),
    .dev_ack     (dev_ack)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; dev_irq = 4'b0; cpu_int_ack = 1'b0; cpu_ipl = 3'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL reset_interrupt got=%b want=0", interrupt); end
    checks++;
    if (vector !== 8'h00) begin failures++; $display("[TB] FAIL reset_vector got=%h want=00", vector); end
    checks++;
    if (int_level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d want=0", int_level); end
    checks++;
    if (dev_ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_dev_ack got=%b want=0000", dev_ack); end
  endtask

  task automatic test_single();
    do_reset();
    dev_vector = 32'h0000_0040; dev_level = 12'o0006; dev_irq = 4'b0001;
    tick();
    checks++;
    if (interrupt !== 1'b1) begin failures++; $display("[TB] FAIL single_interrupt got=%b want=1", interrupt); end
    checks++;
    if (vector !== 8'h40) begin failures++; $display("[TB] FAIL single_vector got=%h want=40", vector); end
    checks++;
    if (int_level !== 3'd6) begin failures++; $display("[TB] FAIL single_level got=%0d want=6", int_level); end
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL single_ack_interrupt got=%b want=0", interrupt); end
    checks++;
    if (dev_ack !== 4'b0001) begin failures++; $display("[TB] FAIL single_dev_ack got=%b want=0001", dev_ack); end
    dev_irq = 4'b0000;
    tick();
    checks++;
    if (dev_ack !== 4'b0000) begin failures++; $display("[TB] FAIL single_ack_width got=%b want=0000", dev_ack); end
    checks++;
    if (vector !== 8'h40) begin failures++; $display("[TB] FAIL single_vector_hold got=%h want=40", vector); end
  endtask

  task automatic test_priority();
    do_reset();
    // dev0 vector has low bits set to confirm they are masked off
    dev_vector = 32'h0000_3C_38_33 | 32'h0;
    dev_level  = {3'd0, 3'd5, 3'd5, 3'd4};
    dev_irq    = 4'b0111;
    tick();
    checks++;
    if (vector !== 8'h38) begin failures++; $display("[TB] FAIL prio_first got=%h want=38", vector); end
    checks++;
    if (int_level !== 3'd5) begin failures++; $display("[TB] FAIL prio_first_level got=%0d want=5", int_level); end
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++;
    if (dev_ack !== 4'b0010) begin failures++; $display("[TB] FAIL prio_ack1 got=%b want=0010", dev_ack); end
    dev_irq = 4'b0101;
    tick();
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL prio_gap got=%b want=0", interrupt); end
    tick();
    checks++;
    if (vector !== 8'h3C) begin failures++; $display("[TB] FAIL prio_tie got=%h want=3c", vector); end
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++;
    if (dev_ack !== 4'b0100) begin failures++; $display("[TB] FAIL prio_ack2 got=%b want=0100", dev_ack); end
    dev_irq = 4'b0001;
    tick(); tick();
    checks++;
    if (vector !== 8'h30) begin failures++; $display("[TB] FAIL prio_last_vector got=%h want=30", vector); end
    checks++;
    if (int_level !== 3'd4) begin failures++; $display("[TB] FAIL prio_last_level got=%0d want=4", int_level); end
    dev_irq = 4'b0000; tick(); tick();
  endtask

  task automatic test_ipl_mask();
    do_reset();
    dev_vector = 32'h0000_0040; dev_level = 12'o0006; cpu_ipl = 3'd6; dev_irq = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL ipl_masked cycle=%0d got=%b want=0", i, interrupt); end
    end
    cpu_ipl = 3'd5;
    tick();
    checks++;
    if (interrupt !== 1'b1) begin failures++; $display("[TB] FAIL ipl_unmask got=%b want=1", interrupt); end
    // Spurious ack while idle must be ignored
    dev_irq = 4'b0000; tick();
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++;
    if (dev_ack !== 4'b0000) begin failures++; $display("[TB] FAIL idle_ack_ignored got=%b want=0000", dev_ack); end
  endtask

  task automatic test_withdrawal();
    do_reset();
    dev_vector = 32'h0000_0040; dev_level = 12'o0006; dev_irq = 4'b0001;
    tick();
    cpu_ipl = 3'd7;
    tick();
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL wd_ipl_interrupt got=%b want=0", interrupt); end
    checks++;
    if (dev_ack !== 4'b0000) begin failures++; $display("[TB] FAIL wd_ipl_ack got=%b want=0000", dev_ack); end
    tick();
    checks++;
    if ((interrupt !== 1'b0) || (dev_ack !== 4'b0000)) begin failures++; $display("[TB] FAIL wd_ipl_after got=%b/%b want=0/0000", interrupt, dev_ack); end
    cpu_ipl = 3'd0;
    tick();
    checks++;
    if (interrupt !== 1'b1) begin failures++; $display("[TB] FAIL wd_regrant got=%b want=1", interrupt); end
    dev_irq = 4'b0000;
    tick();
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL wd_irq_interrupt got=%b want=0", interrupt); end
    tick();
    checks++;
    if (dev_ack !== 4'b0000) begin failures++; $display("[TB] FAIL wd_irq_ack got=%b want=0000", dev_ack); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    dev_vector = 32'h0000_0040; dev_level = 12'o0006; dev_irq = 4'b0001;
    tick();
    cpu_int_ack = 1'b1; dev_irq = 4'b0000;
    tick();
    cpu_int_ack = 1'b0;
    checks++;
    if (dev_ack !== 4'b0001) begin failures++; $display("[TB] FAIL simul_ack got=%b want=0001", dev_ack); end
    tick();
    checks++;
    if (dev_ack !== 4'b0000) begin failures++; $display("[TB] FAIL simul_ack_clear got=%b want=0000", dev_ack); end
  endtask

  task automatic test_preempt();
    do_reset();
    dev_vector = 32'h0000_7030; dev_level = {3'd0, 3'd0, 3'd7, 3'd4}; dev_irq = 4'b0001;
    tick();
    checks++;
    if (vector !== 8'h30) begin failures++; $display("[TB] FAIL pre_initial got=%h want=30", vector); end
    dev_irq = 4'b0011;
    tick();
`ifdef INTR_PREEMPT_EN
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("[TB] FAIL pre_gap got=%b want=0", interrupt); end
    tick();
    checks++;
    if ((interrupt !== 1'b1) || (vector !== 8'h70) || (int_level !== 3'd7)) begin
      failures++; $display("[TB] FAIL pre_switch got=%b/%h/%0d want=1/70/7", interrupt, vector, int_level);
    end
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++;
    if (dev_ack !== 4'b0010) begin failures++; $display("[TB] FAIL pre_ack got=%b want=0010", dev_ack); end
    dev_irq = 4'b0001;
`else
    checks++;
    if ((interrupt !== 1'b1) || (vector !== 8'h30) || (int_level !== 3'd4)) begin
      failures++; $display("[TB] FAIL nopre_hold got=%b/%h/%0d want=1/30/4", interrupt, vector, int_level);
    end
    tick();
    checks++;
    if (vector !== 8'h30) begin failures++; $display("[TB] FAIL nopre_hold2 got=%h want=30", vector); end
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    checks++;
    if (dev_ack !== 4'b0001) begin failures++; $display("[TB] FAIL nopre_ack got=%b want=0001", dev_ack); end
    dev_irq = 4'b0010;
`endif
    tick(); tick();
    checks++;
`ifdef INTR_PREEMPT_EN
    if (vector !== 8'h30) begin failures++; $display("[TB] FAIL pre_next got=%h want=30", vector); end
`else
    if (vector !== 8'h70) begin failures++; $display("[TB] FAIL nopre_next got=%h want=70", vector); end
`endif
    dev_irq = 4'b0000; tick(); tick();
  endtask

  task automatic test_reset_mid();
    // Reset during PENDING, with a CPU ack arriving on the same edge
    do_reset();
    dev_vector = 32'h0000_0040; dev_level = 12'o0006; dev_irq = 4'b0001;
    tick();
    reset = 1'b1; cpu_int_ack = 1'b1; dev_irq = 4'b0000;
    tick();
    reset = 1'b0; cpu_int_ack = 1'b0;
    checks++;
    if ((interrupt !== 1'b0) || (dev_ack !== 4'b0000) || (vector !== 8'h00) || (int_level !== 3'd0)) begin
      failures++; $display("[TB] FAIL rst_pending got=%b/%b/%h/%0d want=0/0000/00/0", interrupt, dev_ack, vector, int_level);
    end
    tick();
    checks++;
    if (dev_ack !== 4'b0000) begin failures++; $display("[TB] FAIL rst_pending_noack got=%b want=0000", dev_ack); end
    // Reset during ACKED
    dev_irq = 4'b0001;
    tick();
    cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
    reset = 1'b1; dev_irq = 4'b0000;
    tick();
    reset = 1'b0;
    checks++;
    if ((interrupt !== 1'b0) || (dev_ack !== 4'b0000) || (vector !== 8'h00) || (int_level !== 3'd0)) begin
      failures++; $display("[TB] FAIL rst_acked got=%b/%b/%h/%0d want=0/0000/00/0", interrupt, dev_ack, vector, int_level);
    end
  endtask

  // Run every scenario in turn, then report
  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; dev_irq = 4'b0; dev_vector = 32'h0; dev_level = 12'h0;
    cpu_ipl = 3'd0; cpu_int_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_ipl_mask();
    test_withdrawal();
    test_simultaneous();
    test_preempt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_arbiter.md
Name: intr_arbiter

Overview:
- Consumes the `interrupt`/`vector` outputs of iopage devices (line clock at 17546, console TTY, disk, etc.) and presents one prioritised bus request to the CPU.
- Performs PDP-11 BR-level arbitration against the current CPU priority (PSW[7:5]).
- Holds the winning vector stable for the CPU and returns a one-cycle acknowledge to the granted device so it can clear its request.

Parameters:
NDEV, 4, number of device request inputs (1..16); index 0 is the highest tie-break priority.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
dev_irq  input  NDEV  per-device interrupt request, level-sensitive
dev_vector  input  8*NDEV  per-device vector; device i occupies bits [8i+7:8i]
dev_level  input  3*NDEV  per-device BR level (4..7 in practice); device i occupies bits [3i+2:3i]
cpu_ipl  input  3  current CPU priority, PSW[7:5]
cpu_int_ack  input  1  one-cycle CPU acknowledge; the CPU has taken the vector
interrupt  output  1  request to the CPU
vector  output  8  vector of the granted request; bits [1:0] are always 0
int_level  output  3  BR level of the granted request
dev_ack  output  NDEV  one-hot, one-cycle acknowledge to the granted device

Behaviour:
- Reset (sync, active-high) forces: state=IDLE, interrupt=0, vector=0, int_level=0, dev_ack=0, internal winner index=0. Reset during PENDING or ACKED abandons the grant, and no dev_ack is issued.
- Eligibility: device i is eligible when dev_irq[i]=1 and dev_level[i] > cpu_ipl, using unsigned 3-bit compare. Consequently a level-0 device is never eligible.
- Winner: the eligible device with the highest dev_level. Ties go to the lowest index. The selection logic is purely combinational and feeds registered state.
- State machine has three states: IDLE, PENDING, ACKED.
  - IDLE:
    - interrupt=0, dev_ack=0.
    - If any device is eligible, latch winner index, vector (with bits [1:0] forced to 0) and level, then go to PENDING.
    - Latency: interrupt rises on the clock edge after dev_irq is first seen eligible, i.e. 1 cycle.
  - PENDING:
    - interrupt=1. vector and int_level are held stable regardless of input changes.
    - If cpu_int_ack=1: assert dev_ack[winner] for the next cycle, drop interrupt on the same edge, and go to ACKED.
    - Else, if dev_irq[winner]=0 (the device withdrew) or cpu_ipl >= the latched level: drop interrupt and go to IDLE (withdrawal). No dev_ack is issued.
    - Simultaneous cpu_int_ack and withdrawal: the ack wins, because the CPU has already committed.
    - A higher-level request arriving in this state does not preempt (see Optional Feature).
  - ACKED:
    - Lasts exactly 1 cycle: dev_ack[winner]=1, interrupt=0. Then go to IDLE, where dev_ack returns to 0.
    - Devices must clear their request on the edge where they sample dev_ack=1. The IDLE cycle that follows therefore arbitrates without the serviced device.
- cpu_int_ack outside PENDING is ignored.
- vector and int_level keep their last value in IDLE/ACKED. They are meaningful only while interrupt=1.
- Back-to-back requests: minimum spacing between acks is 3 cycles (IDLE → PENDING → ACKED).
- dev_ack is never multi-hot and never asserted outside ACKED.

Optional Feature:
- Macro: INTR_PREEMPT_EN.
- When defined, in PENDING without cpu_int_ack, a new eligible device whose dev_level is strictly greater than the latched level forces a return to IDLE. interrupt is low for exactly 1 cycle, then re-arbitration grants the higher device. The original device keeps its request and no dev_ack is issued.
- When not defined, the latched grant is held until ack or withdrawal, as described in Behaviour.

Test Plan:
1. Single request, no contention: reset, cpu_ipl=0, dev_irq[0]=1, dev_vector[0]=0x40 (octal 100, line clock), dev_level[0]=6.
   - Required: interrupt=1, vector=0x40, int_level=6 one cycle later.
   - Then pulse cpu_int_ack: interrupt=0 and dev_ack=4'b0001 for exactly 1 cycle.
2. Priority and tie-break: dev0 at level 4 (vector 0x30), dev1 at level 5 (0x38), dev2 at level 5 (0x3C), all requesting.
   - Required: first grant vector=0x38 (dev1).
   - After ack with dev1 cleared: vector=0x3C (dev2). Then 0x30 (dev0).
3. IPL masking: dev0 at level 6 requesting with cpu_ipl=6 → interrupt stays 0 for 10 cycles. Set cpu_ipl=5 → interrupt=1 the next cycle.
4. Withdrawal: grant dev0 (level 6), then raise cpu_ipl to 7 before ack → interrupt=0 next cycle, state IDLE, no dev_ack. Repeat with dev_irq[0] dropped instead → same response.
5. Simultaneous events and preemption:
   - cpu_int_ack in the same cycle that dev_irq[winner] drops → dev_ack still pulses.
   - Without INTR_PREEMPT_EN, a level-7 request arriving during a level-4 PENDING leaves vector unchanged until ack.
   - With INTR_PREEMPT_EN, interrupt goes low for 1 cycle, then vector switches to the level-7 device.
6. Reset mid-operation: assert reset during PENDING and during ACKED → next cycle interrupt=0, dev_ack=0, vector=0, int_level=0. No ack pulse is ever produced for the abandoned grant.
